dir_input_cond: RTL and testbench

- Upstream conditioner for the adventure-game room FSM.
- Takes four raw, bouncy, asynchronous direction buttons and produces clean, single-cycle, mutually exclusive n/s/e/w move pulses on the game's clock.
- Pipeline per button: synchroniser, then debouncer; followed by a press/release FSM that rejects chorded (multi-button) input.
- Outputs connect directly to the game's n, s, e, w inputs.

---
 rtl/dir_pkg.sv | 18 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/dir_input_cond.sv | 134 +++++++++++++
 tb/tb_dir_input_cond.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// Shared types and direction indices for the direction-button conditioner.
package dir_pkg;

  typedef enum logic {IDLE, HELD} cond_state_t;

  localparam int unsigned DIR_N = 0;
  localparam int unsigned DIR_S = 1;
  localparam int unsigned DIR_E = 2;
  localparam int unsigned DIR_W = 3;

  typedef logic [3:0] dir_vec_t;

  // True when exactly one button is down.
  function automatic logic is_single(dir_vec_t v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus mismatch counter for a single raw button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/dir_input_cond.sv
// Turns four bouncy direction buttons into clean, exclusive one-cycle move pulses.
// Define AUTO_REPEAT_EN to re-emit the held direction every REPEAT_CYCLES cycles.
module dir_input_cond
  import dir_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic conflict,
  output logic held
);

  dir_vec_t    deb;
  cond_state_t state_q, state_d;
  dir_vec_t    dir_q, dir_d;
  logic        conflict_q, conflict_d;
  logic        rpt_fire;
  dir_vec_t    rpt_dir;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_n (
    .clk(clk), .reset(reset), .btn_raw_i(btn_n), .level_o(deb[DIR_N])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_s (
    .clk(clk), .reset(reset), .btn_raw_i(btn_s), .level_o(deb[DIR_S])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_e (
    .clk(clk), .reset(reset), .btn_raw_i(btn_e), .level_o(deb[DIR_E])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_w (
    .clk(clk), .reset(reset), .btn_raw_i(btn_w), .level_o(deb[DIR_W])
  );

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RptW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_CYCLES - 1);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  dir_vec_t        rpt_dir_q, rpt_dir_d;
  logic            rpt_ok_q, rpt_ok_d;

  // Repeats are armed only by a single-button entry and die on any chord change.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_dir_d = rpt_dir_q;
    rpt_ok_d  = rpt_ok_q;
    rpt_fire  = 1'b0;
    if (state_q == IDLE) begin
      rpt_cnt_d = '0;
      rpt_dir_d = deb;
      rpt_ok_d  = is_single(deb);
    end else if (rpt_ok_q && (deb == rpt_dir_q)) begin
      if (rpt_cnt_q == RptLast) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
    end else begin
      rpt_ok_d  = 1'b0;
      rpt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q <= '0;
      rpt_dir_q <= '0;
      rpt_ok_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_dir_q <= rpt_dir_d;
      rpt_ok_q  <= rpt_ok_d;
    end
  end

  assign rpt_dir = rpt_dir_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;
  assign rpt_fire = 1'b0;
  assign rpt_dir  = '0;
`endif

  always_comb begin
    state_d    = state_q;
    dir_d      = '0;
    conflict_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (deb != '0) begin
          state_d = HELD;
          if (is_single(deb)) dir_d = deb;
          else conflict_d = 1'b1;
        end
      end
      HELD: begin
        if (deb == '0) state_d = IDLE;
        else if (rpt_fire) dir_d = rpt_dir;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      conflict_q <= conflict_d;
    end
  end

  assign n        = dir_q[DIR_N];
  assign s        = dir_q[DIR_S];
  assign e        = dir_q[DIR_E];
  assign w        = dir_q[DIR_W];
  assign conflict = conflict_q;
  assign held     = (state_q == HELD);

endmodule

// File: tb/tb_dir_input_cond.sv
// Directed bench for dir_input_cond; outputs compared as {n,s,e,w,conflict,held}.
module tb_dir_input_cond;

  localparam logic [5:0] ON = 6'b100000;
  localparam logic [5:0] OS = 6'b010000;
  localparam logic [5:0] OE = 6'b001000;
  localparam logic [5:0] OW = 6'b000100;
  localparam logic [5:0] OC = 6'b000010;
  localparam logic [5:0] OH = 6'b000001;

  localparam logic [3:0] BN = 4'b0001;
  localparam logic [3:0] BS = 4'b0010;
  localparam logic [3:0] BE = 4'b0100;
  localparam logic [3:0] BW = 4'b1000;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic       n, s, e, w, conflict, held;

  int checks = 0;
  int errors = 0;
  int pulse_log[$];
  bit log_en = 0;

  dir_input_cond #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn[0]), .btn_s(btn[1]), .btn_e(btn[2]), .btn_w(btn[3]),
    .n(n), .s(s), .e(e), .w(w), .conflict(conflict), .held(held)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Exclusivity of the pulse outputs, every cycle, plus direction-pulse log.
  always @(negedge clk) begin
    checks++;
    assert ($countones({n, s, e, w, conflict}) <= 1) else begin
      errors++;
      $error("FAIL onehot observed=%b expected=at most one high", {n, s, e, w, conflict});
    end
    if (log_en) begin
      if (n) pulse_log.push_back(0);
      if (s) pulse_log.push_back(1);
      if (e) pulse_log.push_back(2);
      if (w) pulse_log.push_back(3);
    end
  end

  task automatic tick_check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    @(posedge clk);
    @(negedge clk);
    obs = {n, s, e, w, conflict, held};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Press from IDLE: six quiet edges, pulse on the seventh, one held cycle,
  // then release: six held edges and back to IDLE.
  task automatic press_release(input string tag, input logic [3:0] b, input logic [5:0] pulse);
    btn = b;
    repeat (6) tick_check({tag, "_wait"}, 6'b0);
    tick_check({tag, "_pulse"}, pulse | OH);
    tick_check({tag, "_held"}, OH);
    btn = 4'b0;
    repeat (6) tick_check({tag, "_rel"}, OH);
    tick_check({tag, "_idle"}, 6'b0);
  endtask

  initial begin
    int exp_seq[5];
    int got;
    exp_seq = '{2, 1, 3, 2, 2};
    btn   = 4'b0;
    reset = 1'b1;
    repeat (3) tick_check("reset", 6'b0);
    reset = 1'b0;
    tick_check("post_reset", 6'b0);

    // Clean east press.
    press_release("east", BE, OE);

    // South bounce 1-0-1-0 then steady.
    btn = BS; tick_check("bounce", 6'b0);
    btn = 4'b0; tick_check("bounce", 6'b0);
    btn = BS; tick_check("bounce", 6'b0);
    btn = 4'b0; tick_check("bounce", 6'b0);
    press_release("south_bounce", BS, OS);

    // North+west chord, then a clean west press with a late east ignored.
    press_release("chord", BN | BW, OC);
    btn = BW;
    repeat (6) tick_check("west_wait", 6'b0);
    tick_check("west_pulse", OW | OH);
    tick_check("west_held", OH);
    btn = BW | BE;
    repeat (8) tick_check("second_ignored", OH);
    btn = 4'b0;
    repeat (6) tick_check("west_rel", OH);
    tick_check("west_idle", 6'b0);

    // Long east hold.
    btn = BE;
    repeat (6) tick_check("long_wait", 6'b0);
    tick_check("long_pulse", OE | OH);
    for (int i = 0; i < 17; i++) begin
`ifdef AUTO_REPEAT_EN
      tick_check("long_hold", (i == 7 || i == 15) ? (OE | OH) : OH);
`else
      tick_check("long_hold", OH);
`endif
    end
    btn = 4'b0;
    repeat (6) tick_check("long_rel", OH);
    tick_check("long_idle", 6'b0);

    // Reset lands on the edge where the south pulse is due.
    btn = BS;
    repeat (6) tick_check("rst_wait", 6'b0);
    reset = 1'b1;
    tick_check("rst_cancel", 6'b0);
    reset = 1'b0;
    repeat (6) tick_check("rst_rewait", 6'b0);
    tick_check("rst_pulse", OS | OH);
    tick_check("rst_held", OH);
    btn = 4'b0;
    repeat (6) tick_check("rst_rel", OH);
    tick_check("rst_idle", 6'b0);

    // Game sequence e, s, w, e, e.
    pulse_log.delete();
    log_en = 1;
    press_release("seq_e1", BE, OE);
    press_release("seq_s", BS, OS);
    press_release("seq_w", BW, OW);
    press_release("seq_e2", BE, OE);
    press_release("seq_e3", BE, OE);
    log_en = 0;
    checks++;
    assert (pulse_log.size() === 5) else begin
      errors++;
      $error("FAIL seq_count observed=%0d expected=5", pulse_log.size());
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < pulse_log.size()) ? pulse_log[i] : -1;
      checks++;
      assert (got === exp_seq[i]) else begin
        errors++;
        $error("FAIL seq_order[%0d] observed=%0d expected=%0d", i, got, exp_seq[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
